ped_request_debouncer: RTL and testbench

Conditions the raw pedestrian push-button of the traffic-light intersection and turns each clean press into a held crossing request for the traffic-light controller directly downstream. Synchronises the asynchronous button, debounces it with a stability counter and edge-detects the debounced level. A request/acknowledge FSM holds the request until the controller accepts it, then applies a hold-off window. Presses that cannot be accepted are counted.

---
 rtl/ped_request_debouncer.sv | 155 +++++++++++++++
 tb/tb_ped_request_debouncer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ped_request_debouncer.sv
// ped_request_debouncer
//   Conditions the raw pedestrian push-button and turns each clean press into
//   a crossing request that is held until the traffic-light controller
//   acknowledges it. A hold-off window follows each acknowledge. Presses that
//   cannot be accepted are counted in a saturating 8-bit counter.
//
// Parameters
//   STABLE_CYCLES   consecutive synchronised cycles the button must differ
//                   from the debounced level before the level flips (>=1)
//   HOLDOFF_CYCLES  cycles after an acknowledge during which presses are
//                   rejected (0 = no hold-off)
//
// Ports
//   i_w_clk          system clock, rising edge
//   i_w_reset        asynchronous active-low reset
//   i_w_button       raw, asynchronous, bouncing button level (1 = pressed)
//   i_w_ack          request accepted by the controller
//   o_w_pressed      debounced button level
//   o_w_press_pulse  high for the first cycle o_w_pressed is 1
//   o_w_request      crossing request, held until acknowledged
//   o_w_drop_count   rejected presses, saturating at 255
module ped_request_debouncer #(
  parameter int STABLE_CYCLES  = 4,
  parameter int HOLDOFF_CYCLES = 8
) (
  input  logic       i_w_clk,
  input  logic       i_w_reset,
  input  logic       i_w_button,
  input  logic       i_w_ack,
  output logic       o_w_pressed,
  output logic       o_w_press_pulse,
  output logic       o_w_request,
  output logic [7:0] o_w_drop_count
);

  localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
  // The hold-off counter only ever holds HOLDOFF_CYCLES-1 down to 0.
  localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD =
    HOLD_W'((HOLDOFF_CYCLES > 0) ? (HOLDOFF_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  logic              sync_meta_reg;
  logic              sync_s_reg;
  logic              debounced_reg;
  logic              debounced_q_reg;
  logic [CNT_W-1:0]  cnt_reg;
  state_t            state_reg;
  state_t            state_next;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [HOLD_W-1:0] hold_cnt_next;
  logic              request_reg;
  logic [7:0]        drop_count_reg;
  logic              press_pulse;
  logic              drop;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      sync_meta_reg <= 1'b0;
      sync_s_reg    <= 1'b0;
    end else begin
      sync_meta_reg <= i_w_button;
      sync_s_reg    <= sync_meta_reg;
    end
  end

  // Stability counter: the level only flips after STABLE_CYCLES consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      debounced_reg   <= 1'b0;
      debounced_q_reg <= 1'b0;
      cnt_reg         <= '0;
    end else begin
      debounced_q_reg <= debounced_reg;
      if (sync_s_reg == debounced_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        debounced_reg <= sync_s_reg;
        cnt_reg       <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign press_pulse = debounced_reg & ~debounced_q_reg;

  // A press is rejected whenever the FSM is not idle, including the cycle in
  // which an acknowledge moves it out of PENDING.
  assign drop = press_pulse & (state_reg != IDLE);

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (press_pulse) begin
          state_next = PENDING;
        end
      end
      PENDING: begin
        if (i_w_ack) begin
          if (HOLDOFF_CYCLES == 0) begin
            state_next = IDLE;
          end else begin
            state_next    = HOLDOFF;
            hold_cnt_next = HOLD_LOAD;
          end
        end
      end
      HOLDOFF: begin
        if (hold_cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          hold_cnt_next = hold_cnt_reg - 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      state_reg      <= IDLE;
      hold_cnt_reg   <= '0;
      request_reg    <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      // Registered decode, so the request tracks the state it will be in.
      request_reg  <= (state_next == PENDING);
      if (drop && (drop_count_reg != 8'hFF)) begin
        drop_count_reg <= drop_count_reg + 8'd1;
      end
    end
  end

  assign o_w_pressed     = debounced_reg;
  assign o_w_press_pulse = press_pulse;
  assign o_w_request     = request_reg;
  assign o_w_drop_count  = drop_count_reg;

endmodule

// File: tb/tb_ped_request_debouncer.sv
// Directed testbench for ped_request_debouncer (STABLE_CYCLES=4,
// HOLDOFF_CYCLES=8, 4 ns clock). Expected values are queued when stimulus is
// applied and popped when the corresponding DUT output is sampled.
module tb_ped_request_debouncer;

  logic       clk;
  logic       rst_n;
  logic       button;
  logic       ack;
  logic       pressed;
  logic       pulse;
  logic       request;
  logic [7:0] drop_count;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  ped_request_debouncer #(
    .STABLE_CYCLES (4),
    .HOLDOFF_CYCLES(8)
  ) dut (
    .i_w_clk        (clk),
    .i_w_reset      (rst_n),
    .i_w_button     (button),
    .i_w_ack        (ack),
    .o_w_pressed    (pressed),
    .o_w_press_pulse(pulse),
    .o_w_request    (request),
    .o_w_drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  task automatic expect_val(input string tag, input logic [31:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    exp_q.push_back(e);
  endtask

  task automatic compare(input logic [31:0] observed);
    exp_t e;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0h, expected an entry", observed);
    end else begin
      e = exp_q.pop_front();
      assert (observed === e.value)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h, expected %0h", e.tag, observed, e.value);
      end
    end
  endtask

  // Advance one clock edge and sample/drive 1 ns after it.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold the button pressed until the press pulse appears (bounded).
  task automatic press_wait_pulse(input string tag);
    bit seen;
    seen   = 1'b0;
    button = 1'b1;
    expect_val(tag, 1);
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      if (pulse === 1'b1) seen = 1'b1;
    end
    compare({31'd0, seen});
  endtask

  initial begin
    int pulses;
    int req_low;
    int any_out;

    rst_n  = 1'b0;
    button = 1'b1;
    ack    = 1'b0;

    // Reset held with button pressed: all outputs 0.
    #10;
    expect_val("reset_pressed", 0);    compare({31'd0, pressed});
    expect_val("reset_pulse", 0);      compare({31'd0, pulse});
    expect_val("reset_request", 0);    compare({31'd0, request});
    expect_val("reset_drop", 0);       compare({24'd0, drop_count});
    #1 rst_n = 1'b1;                   // released at 11 ns, edge k at 14 ns

    // Button still pressed: level rises after edge k+5.
    expect_val("post_reset_pressed_k4", 0);
    tick(5);
    compare({31'd0, pressed});
    expect_val("post_reset_pressed_k5", 1);
    expect_val("post_reset_pulse_k5", 1);
    tick(1);
    compare({31'd0, pressed});
    compare({31'd0, pulse});
    expect_val("post_reset_pulse_k6", 0);
    expect_val("post_reset_request_k6", 1);
    tick(1);
    compare({31'd0, pulse});
    compare({31'd0, request});

    // Release while PENDING: no pulse, request held.
    button = 1'b0;
    expect_val("release_pressed", 0);
    expect_val("release_request_held", 1);
    expect_val("release_drop", 0);
    tick(8);
    compare({31'd0, pressed});
    compare({31'd0, request});
    compare({24'd0, drop_count});

    // One-cycle ack, then a press pulsing inside hold-off is dropped.
    ack = 1'b1;
    expect_val("ack_request_low", 0);
    tick(1);                            // edge n
    ack    = 1'b0;
    button = 1'b1;
    compare({31'd0, request});
    expect_val("holdoff_pulse_n5", 0);
    tick(5);
    compare({31'd0, pulse});
    expect_val("holdoff_pulse_n6", 1);
    tick(1);
    compare({31'd0, pulse});
    expect_val("holdoff_drop", 1);
    expect_val("holdoff_request", 0);
    tick(1);
    compare({24'd0, drop_count});
    compare({31'd0, request});

    // After hold-off a fresh press raises the request.
    button = 1'b0;
    tick(8);
    press_wait_pulse("after_holdoff_pulse");
    expect_val("after_holdoff_request", 1);
    tick(1);
    compare({31'd0, request});

    // Press while PENDING: dropped, request stays.
    button = 1'b0;
    tick(8);
    press_wait_pulse("pending_press_pulse");
    expect_val("pending_press_drop", 2);
    expect_val("pending_press_request", 1);
    tick(1);
    compare({24'd0, drop_count});
    compare({31'd0, request});

    // Pulse coincident with ack: ack wins, pulse dropped.
    button = 1'b0;
    tick(8);
    button = 1'b1;
    tick(6);
    expect_val("coincident_pulse", 1);
    compare({31'd0, pulse});
    ack = 1'b1;
    expect_val("coincident_request", 0);
    expect_val("coincident_drop", 3);
    tick(1);
    ack = 1'b0;
    compare({31'd0, request});
    compare({24'd0, drop_count});
    expect_val("coincident_holdoff_request", 0);
    tick(3);
    compare({31'd0, request});

    // Glitch of 3 cycles is filtered (hold-off long expired by then).
    button = 1'b0;
    tick(10);
    button = 1'b1;
    any_out = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      any_out |= {29'd0, pressed, pulse, request};
    end
    button = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      any_out |= {29'd0, pressed, pulse, request};
    end
    expect_val("glitch_outputs", 0);   compare(any_out);
    expect_val("glitch_drop", 3);      compare({24'd0, drop_count});

    // Bouncing press, then a stable hold.
    button = 1'b1; tick(1);
    button = 1'b0; tick(1);
    button = 1'b1; tick(1);
    button = 1'b0; tick(1);
    button = 1'b1;                      // stable before edge k
    expect_val("bounce_pressed_k4", 0);
    tick(5);
    compare({31'd0, pressed});
    expect_val("bounce_pressed_k5", 1);
    tick(1);
    compare({31'd0, pressed});
    pulses = (pulse === 1'b1) ? 1 : 0;
    expect_val("bounce_request_k6", 1);
    tick(1);
    compare({31'd0, request});
    req_low = 0;
    for (int i = 0; i < 20; i++) begin
      if (pulse === 1'b1) pulses++;
      if (request !== 1'b1) req_low++;
      tick(1);
    end
    expect_val("bounce_single_pulse", 1);   compare(pulses);
    expect_val("bounce_request_held", 0);   compare(req_low);

    // 260 rejected presses while PENDING: count saturates.
    for (int i = 0; i < 260; i++) begin
      button = 1'b0;
      tick(7);
      button = 1'b1;
      tick(7);
    end
    expect_val("saturate_drop", 255);      compare({24'd0, drop_count});
    expect_val("saturate_request", 1);     compare({31'd0, request});

    // Asynchronous reset while PENDING clears outputs before the next edge.
    rst_n = 1'b0;
    #1;
    expect_val("async_reset_request", 0);  compare({31'd0, request});
    expect_val("async_reset_drop", 0);     compare({24'd0, drop_count});
    expect_val("async_reset_pressed", 0);  compare({31'd0, pressed});
    tick(2);
    rst_n = 1'b1;
    tick(2);

    expect_val("scoreboard_drained", 0);
    compare(exp_q.size() - 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
